// File: rtl/data_link_pkg.sv
// Word layout and FSM state encodings shared by the GPIO transmitter and receiver.
// Both ends of the link must agree on these, so they live in one place.
package data_link_pkg;

  localparam int WORD_W  = 10;
  localparam int X_MSB   = 9;
  localparam int X_LSB   = 6;
  localparam int Y_MSB   = 5;
  localparam int Y_LSB   = 2;
  localparam int VAL_MSB = 1;
  localparam int VAL_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } link_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [3:0] x,
                                                  input logic [3:0] y,
                                                  input logic [1:0] v);
    logic [WORD_W-1:0] w;
    w = '0;
    w[X_MSB:X_LSB]     = x;
    w[Y_MSB:Y_LSB]     = y;
    w[VAL_MSB:VAL_LSB] = v;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Power-of-two circular FIFO; full/empty come straight from the registered count.
// A push into a full FIFO or a pop from an empty one is ignored.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/data_output.sv
// Queues (X,Y,VALUE) updates and drives them to GPIO as setup/strobe/gap frames.
// A push becomes visible to the FSM one cycle after it lands, giving DATA_OUT at k+2.
module data_output
  import data_link_pkg::*;
#(
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 8,
  parameter int GAP_CYCLES    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  X_COORD,
  input  logic [3:0]  Y_COORD,
  input  logic [1:0]  VALUE,
  input  logic        WRITE_EN,
  output logic        READY,
  output logic [9:0]  DATA_OUT,
  output logic        ENABLE_OUT,
  output logic        BUSY
);

  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              avail_q, avail_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;

  assign fifo_push  = WRITE_EN && !fifo_full;
  assign READY      = !fifo_full;
  assign DATA_OUT   = data_q;
  assign ENABLE_OUT = en_q;
  assign BUSY       = (state_q != ST_IDLE) || !fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_tx_fifo (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pack_word(X_COORD, Y_COORD, VALUE)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    en_d     = 1'b0;
    fifo_pop = 1'b0;
    avail_d  = !fifo_empty;
    case (state_q)
      ST_IDLE: begin
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_dout;
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          en_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      avail_q <= avail_d;
    end
  end

endmodule

// File: tb/tb_data_output.sv
// Bench for data_output: a queue-based timing model predicts every output each cycle,
// and a small GPIO receiver captures the word on each strobe rising edge.
module tb_data_output;

  localparam int S = 4, STB = 8, G = 8, D = 4;
  localparam int PERIOD = 1 + S + STB + G;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] X_COORD = 4'd0;
  logic [3:0] Y_COORD = 4'd0;
  logic [1:0] VALUE = 2'd0;
  logic       WRITE_EN = 1'b0;
  logic       READY, ENABLE_OUT, BUSY;
  logic [9:0] DATA_OUT;

  int compared = 0;
  int mismatched = 0;

  data_output #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(STB), .GAP_CYCLES(G), .FIFO_DEPTH(D)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .X_COORD(X_COORD), .Y_COORD(Y_COORD),
    .VALUE(VALUE), .WRITE_EN(WRITE_EN), .READY(READY), .DATA_OUT(DATA_OUT),
    .ENABLE_OUT(ENABLE_OUT), .BUSY(BUSY)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: a queue of accepted words tagged with their push edge.
  typedef struct { logic [9:0] w; int t; } entry_t;
  entry_t     mq[$];
  int         edge_n = 0;
  int         next_free = 0;
  int         en_rise = -100;
  int         en_fall = -100;
  logic [9:0] exp_data = 10'd0;
  logic       exp_en = 1'b0, exp_ready = 1'b1, exp_busy = 1'b0, acc = 1'b0;

  logic [9:0] rx_q[$];
  int         rise_edges[$];
  logic       en_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (ENABLE_OUT === 1'b1 && en_prev === 1'b0) begin
      rx_q.push_back(DATA_OUT);
      rise_edges.push_back(edge_n);
    end
    en_prev = ENABLE_OUT;
  end

  function automatic logic [9:0] mk(input int x, input int y, input int v);
    return 10'(x * 64 + y * 4 + v);
  endfunction

  task automatic model_reset();
    mq.delete();
    next_free = 0; en_rise = -100; en_fall = -100;
    exp_data = 10'd0; exp_en = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0; acc = 1'b0;
  endtask

  // A word pushed at edge t may be popped no earlier than edge t+2, and only when no
  // frame is running; a frame occupies SETUP+STROBE+GAP cycles plus one IDLE cycle.
  task automatic model_edge(input logic wr, input logic [9:0] w);
    bit     rdy_before;
    entry_t e;
    edge_n++;
    rdy_before = (mq.size() < D);
    acc = 1'b0;
    if (edge_n >= next_free && mq.size() > 0 && mq[0].t <= edge_n - 2) begin
      exp_data  = mq[0].w;
      mq.delete(0);
      en_rise   = edge_n + S;
      en_fall   = en_rise + STB;
      next_free = en_fall + G + 1;
    end
    if (wr && rdy_before) begin
      e.w = w; e.t = edge_n;
      mq.push_back(e);
      acc = 1'b1;
    end
    exp_en    = (edge_n >= en_rise) && (edge_n < en_fall);
    exp_ready = (mq.size() < D);
    exp_busy  = (edge_n < next_free - 1) || (mq.size() > 0);
  endtask

  task automatic step(input logic wr, input logic [9:0] w);
    WRITE_EN = wr;
    X_COORD  = w[9:6];
    Y_COORD  = w[5:2];
    VALUE    = w[1:0];
    @(posedge CLOCK_50);
    model_edge(wr, w);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    compared++;
    if (DATA_OUT !== 10'd0 || ENABLE_OUT !== 1'b0 || READY !== 1'b1 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: data=%h en=%b rdy=%b busy=%b, want 000/0/1/0",
               DATA_OUT, ENABLE_OUT, READY, BUSY);
    end
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int k, first_hi, n_hi, off;
    first_hi = -1; n_hi = 0;
    step(1'b1, mk(3, 5, 2));
    k = edge_n;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 10'd0);
      off = edge_n - k;
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL single_cycle edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", off,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
      if (off == 1) begin
        compared++;
        if (DATA_OUT !== 10'd0) begin
          mismatched++; $display("FAIL single_early_data: got %h want 000", DATA_OUT);
        end
      end
      if (off == 2) begin
        compared++;
        if (DATA_OUT !== 10'h0D6) begin
          mismatched++; $display("FAIL single_data_k2: got %h want 0d6", DATA_OUT);
        end
      end
      if (ENABLE_OUT === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = off;
      end
    end
    compared++;
    if (first_hi !== 6 || n_hi !== 8) begin
      mismatched++;
      $display("FAIL single_strobe: rise at k+%0d for %0d cycles, want k+6 for 8", first_hi, n_hi);
    end
  endtask

  task automatic test_fill();
    logic [9:0] w[5];
    logic [9:0] a;
    a = 10'($urandom);
    for (int i = 0; i < 5; i++) w[i] = 10'($urandom);
    rx_q.delete(); rise_edges.delete();
    step(1'b1, a);
    for (int i = 0; i < 3; i++) step(1'b0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w[i]);
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL fill_push %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
      if (i == 3) begin
        compared++;
        if (READY !== 1'b0) begin
          mismatched++; $display("FAIL fill_ready_low: got %b want 0", READY);
        end
      end
    end
    for (int i = 0; i < 5 * PERIOD + 5; i++) begin
      step(1'b0, 10'd0);
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL fill_drain edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
    end
    compared++;
    if (rx_q.size() != 5 || rise_edges.size() != 5) begin
      mismatched++;
      $display("FAIL fill_frames: got %0d frames want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (rx_q[i] !== ((i == 0) ? a : w[i-1])) begin
          mismatched++;
          $display("FAIL fill_order %0d: got %h want %h", i, rx_q[i], (i == 0) ? a : w[i-1]);
        end
        if (i > 0) begin
          compared++;
          if (rise_edges[i] - rise_edges[i-1] != PERIOD) begin
            mismatched++;
            $display("FAIL fill_period %0d: got %0d want %0d", i,
                     rise_edges[i] - rise_edges[i-1], PERIOD);
          end
        end
      end
    end
  endtask

  task automatic test_strobe_push();
    logic [9:0] a, b;
    int ka, change_at;
    a = mk(1, 2, 3);
    b = a ^ 10'h3FF;
    change_at = -1;
    step(1'b1, a);
    ka = edge_n;
    for (int i = 0; i < S + 3; i++) step(1'b0, 10'd0);
    step(1'b1, b);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step(1'b0, 10'd0);
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL strobe_push edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
      if (change_at < 0 && DATA_OUT === b) change_at = edge_n - ka;
    end
    compared++;
    if (change_at != 2 + PERIOD) begin
      mismatched++;
      $display("FAIL strobe_push_change: new word at k+%0d want k+%0d", change_at, 2 + PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, mk(7, 7, 1));
    step(1'b1, mk(8, 9, 2));
    step(1'b1, mk(15, 0, 3));
    for (int i = 0; i < S + 2; i++) step(1'b0, 10'd0);
    compared++;
    if (ENABLE_OUT !== 1'b1) begin
      mismatched++; $display("FAIL reset_mid_pre: en=%b want 1", ENABLE_OUT);
    end
    rx_q.delete();
    RESET = 1'b1;
    #1;
    compared++;
    if (ENABLE_OUT !== 1'b0 || DATA_OUT !== 10'd0 || READY !== 1'b1 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_async: en=%b data=%h rdy=%b busy=%b want 0/000/1/0",
               ENABLE_OUT, DATA_OUT, READY, BUSY);
    end
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step(1'b0, 10'd0);
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL reset_mid_after edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
    end
    compared++;
    if (rx_q.size() != 0) begin
      mismatched++; $display("FAIL reset_mid_frames: got %0d frames want 0", rx_q.size());
    end
  endtask

  task automatic test_full_pop();
    logic [9:0] w[6];
    int ka, acc_at, guard;
    for (int i = 0; i < 6; i++) w[i] = 10'($urandom);
    rx_q.delete();
    acc_at = -1; guard = 0;
    step(1'b1, w[0]);
    ka = edge_n;
    for (int i = 0; i < 2; i++) step(1'b0, 10'd0);
    for (int i = 1; i < 5; i++) step(1'b1, w[i]);
    while (acc_at < 0 && guard < 4 * PERIOD) begin
      step(1'b1, w[5]);
      guard++;
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL full_pop edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n - ka,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
      if (edge_n - ka == 2 + PERIOD) begin
        compared++;
        if (READY !== 1'b1 || DATA_OUT !== w[1]) begin
          mismatched++;
          $display("FAIL full_pop_edge: rdy=%b data=%h want 1/%h", READY, DATA_OUT, w[1]);
        end
      end
      if (acc) acc_at = edge_n - ka;
    end
    compared++;
    if (acc_at != 3 + PERIOD) begin
      mismatched++; $display("FAIL full_pop_accept: accepted at k+%0d want k+%0d", acc_at, 3 + PERIOD);
    end
    for (int i = 0; i < 5 * PERIOD + 5; i++) begin
      step(1'b0, 10'd0);
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL full_pop_drain edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
    end
    compared++;
    if (rx_q.size() != 6) begin
      mismatched++; $display("FAIL full_pop_frames: got %0d want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        compared++;
        if (rx_q[i] !== w[i]) begin
          mismatched++; $display("FAIL full_pop_order %0d: got %h want %h", i, rx_q[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int sx[16], sy[16], sv[16];
    int sent, guard;
    sent = 0; guard = 0;
    rx_q.delete();
    for (int i = 0; i < 16; i++) begin
      sx[i] = $urandom_range(0, 15); sy[i] = $urandom_range(0, 15); sv[i] = $urandom_range(0, 3);
    end
    while (sent < 16 && guard < 3000) begin
      guard++;
      if ($urandom_range(0, 3) == 0) step(1'b0, 10'd0);
      else step(1'b1, mk(sx[sent], sy[sent], sv[sent]));
      if (acc) sent++;
      compared++;
      if (DATA_OUT !== exp_data || ENABLE_OUT !== exp_en || READY !== exp_ready || BUSY !== exp_busy) begin
        mismatched++;
        $display("FAIL loopback edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", edge_n,
                 DATA_OUT, ENABLE_OUT, READY, BUSY, exp_data, exp_en, exp_ready, exp_busy);
      end
    end
    compared++;
    if (sent != 16) begin
      mismatched++; $display("FAIL loopback_timeout: sent %0d want 16", sent);
    end
    for (int i = 0; i < 6 * PERIOD; i++) step(1'b0, 10'd0);
    compared++;
    if (rx_q.size() != 16) begin
      mismatched++; $display("FAIL loopback_count: got %0d want 16", rx_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        compared++;
        if (int'(rx_q[i][9:6]) != sx[i] || int'(rx_q[i][5:2]) != sy[i] || int'(rx_q[i][1:0]) != sv[i]) begin
          mismatched++;
          $display("FAIL loopback_tuple %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                   rx_q[i][9:6], rx_q[i][5:2], rx_q[i][1:0], sx[i], sy[i], sv[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_strobe_push();
    test_reset_mid();
    test_full_pop();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
